param_seq_alu: RTL

- Parametrised, handshaked successor to the 16-bit breadboard ALU; it keeps the same 4-bit opcode map and WIDTH defaults to 16.
- Single-cycle logic, add and shift ops complete one cycle after accept.
- MUL, DIV and MOD run on an iterative shift-add / restoring-divide datapath, WIDTH cycles each.
- Sits between the operand source and the result consumer using valid/ready on both sides; it holds the previous result for NOP.

---
 rtl/param_seq_alu.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/param_seq_alu.sv
// Handshaked parametrised ALU: bitwise/add/shift ops finish on the accept edge,
// MUL/DIV/MOD iterate one bit per cycle for WIDTH cycles on a shared hi/lo datapath.
module param_seq_alu #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             error,
   output logic [WIDTH-1:0] prev_output
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_MUL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_NOT  = 4'b0111;
   localparam logic [3:0] OP_MOD  = 4'b1000;
   localparam logic [3:0] OP_NAND = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1010;
   localparam logic [3:0] OP_XNOR = 4'b1011;
   localparam logic [3:0] OP_SUB  = 4'b1100;
   localparam logic [3:0] OP_DIV  = 4'b1101;
   localparam logic [3:0] OP_SLL  = 4'b1110;
   localparam logic [3:0] OP_CLR  = 4'b1111;

   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic [3:0]       op_reg;
   logic [SHW-1:0]   count;
   logic [WIDTH-1:0] hi, lo;

   logic [WIDTH-1:0] quick_result;
   logic             quick_error;
   logic [WIDTH:0]   add_full, sub_full;
   logic             is_iter;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
   logic [WIDTH:0]   div_shift, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] div_hi_n, div_lo_n;
   logic [WIDTH-1:0] iter_result;
   logic             iter_error;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign is_iter   = (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_MOD);

   always_comb begin
      add_full     = {1'b0, a_in} + {1'b0, b_in};
      sub_full     = {1'b0, a_in} - {1'b0, b_in};
      quick_result = '0;
      quick_error  = 1'b0;
      case (opcode)
         OP_NOP:  quick_result = prev_output;
         OP_AND:  quick_result = a_in & b_in;
         OP_OR:   quick_result = a_in | b_in;
         OP_XOR:  quick_result = a_in ^ b_in;
         OP_NAND: quick_result = ~(a_in & b_in);
         OP_NOR:  quick_result = ~(a_in | b_in);
         OP_XNOR: quick_result = ~(a_in ^ b_in);
         OP_NOT:  quick_result = ~a_in;
         OP_ADD: begin
            quick_result = add_full[WIDTH-1:0];
            quick_error  = add_full[WIDTH];
         end
         OP_SUB: begin
            quick_result = sub_full[WIDTH-1:0];
            quick_error  = sub_full[WIDTH];
         end
         OP_SRL:  quick_result = a_in >> b_in[SHW-1:0];
         OP_SLL:  quick_result = a_in << b_in[SHW-1:0];
         OP_CLR:  quick_result = '0;
         default: quick_result = '0;
      endcase
   end

   // MUL: {hi,lo} shifts right with lo starting as the multiplier; DIV/MOD: restoring
   // divide with hi as remainder and lo as dividend/quotient. b=0 falls out naturally.
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_reg} : '0);
      mul_hi_n  = mul_sum[WIDTH:1];
      mul_lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
      div_shift = {hi, lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_reg});
      div_diff  = div_shift - {1'b0, b_reg};
      div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_lo_n  = {lo[WIDTH-2:0], div_ge};
      iter_result = '0;
      iter_error  = 1'b0;
      case (op_reg)
         OP_MUL: begin
            iter_result = mul_lo_n;
            iter_error  = |mul_hi_n;
         end
         OP_DIV: begin
            iter_result = div_lo_n;
            iter_error  = (b_reg == '0);
         end
         OP_MOD: begin
            iter_result = div_hi_n;
            iter_error  = (b_reg == '0);
         end
         default: iter_result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         op_reg      <= '0;
         count       <= '0;
         hi          <= '0;
         lo          <= '0;
         result      <= '0;
         error       <= 1'b0;
         prev_output <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg  <= a_in;
                  b_reg  <= b_in;
                  op_reg <= opcode;
                  count  <= '0;
                  if (is_iter) begin
                     hi    <= '0;
                     lo    <= (opcode == OP_MUL) ? b_in : a_in;
                     state <= BUSY;
                  end else begin
                     result <= quick_result;
                     error  <= quick_error;
                     state  <= DONE;
                  end
               end
            end
            BUSY: begin
               count <= count + SHW'(1);
               if (op_reg == OP_MUL) begin
                  hi <= mul_hi_n;
                  lo <= mul_lo_n;
               end else begin
                  hi <= div_hi_n;
                  lo <= div_lo_n;
               end
               if (count == LAST) begin
                  result <= iter_result;
                  error  <= iter_error;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  prev_output <= result;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
